// File: rtl/store_queue.sv
// Store queue between the MEM stage and the data-memory write channel.
// Aligns stores onto byte lanes, flags misaligned requests and issues accepted stores in order.
module store_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [1:0]                   req_size,
    input  logic [DATA_W-1:0]            req_data,
    output logic                         misalign_err,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_data,
    output logic [DATA_W/8-1:0]          mem_strb,
    input  logic [ADDR_W-1:0]            ld_addr,
    output logic                         ld_conflict,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(STRB_W - 1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [STRB_W-1:0] r_strb [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_misalign;

    logic [OFF_W-1:0]  w_off;
    logic [3:0]        w_nbytes;
    logic              w_illegal;
    logic [STRB_W-1:0] w_lane_en;
    logic [DATA_W-1:0] w_lane_mask;
    logic [STRB_W-1:0] w_strb;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] w_word_addr;
    logic [ADDR_W-1:0] w_ld_word;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_conflict;

    // Request decode: a legal store occupies nbytes lanes starting at its offset.
    // NOTE: every always_comb output gets a default before any branch so no latch can be inferred.
    always_comb begin
        w_off       = req_addr[OFF_W-1:0];
        w_nbytes    = 4'd1 << req_size;
        w_illegal   = (int'(w_nbytes) > STRB_W) ||
                      ((int'(w_off) & (int'(w_nbytes) - 1)) != 0);
        w_lane_en   = '0;
        w_lane_mask = '0;
        for (int b = 0; b < STRB_W; b++) begin
            w_lane_en[b]         = (b < int'(w_nbytes));
            w_lane_mask[8*b +: 8] = {8{w_lane_en[b]}};
        end
        w_strb      = w_lane_en << w_off;
        w_data      = (req_data & w_lane_mask) << {w_off, 3'b000};
        w_word_addr = req_addr & ~OFF_MASK;
        w_ld_word   = ld_addr & ~OFF_MASK;
    end

    assign req_ready    = (r_count != CNT_W'(DEPTH));
    assign empty        = (r_count == '0);
    assign count        = r_count;
    assign mem_valid    = !empty;
    assign misalign_err = r_misalign;
    assign mem_addr     = r_addr[r_head];
    assign mem_data     = r_data[r_head];
    assign mem_strb     = r_strb[r_head];

    assign w_accept = req_valid && req_ready;
    assign w_push   = w_accept && !w_illegal;
    assign w_pop    = mem_valid && mem_ready;

    // Per-entry valid bits keep the load lookup independent of pointer arithmetic.
    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] == w_ld_word)) begin
                w_conflict = 1'b1;
            end
        end
    end

    assign ld_conflict = w_conflict;

    // Push and pop never touch the same slot: push needs count < DEPTH, pop needs count > 0,
    // and head == tail only at those two extremes.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
            r_vld      <= '0;
            // NOTE: entry storage is reset too, so the write port shows zeros after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_strb[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
            r_misalign <= w_accept && w_illegal;
            if (w_push) begin
                r_addr[r_tail] <= w_word_addr;
                r_data[r_tail] <= w_data;
                r_strb[r_tail] <= w_strb;
                r_vld[r_tail]  <= 1'b1;
                r_tail         <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: a 32-bit and a 64-bit instance checked every cycle against
// a queue-based reference model, plus directed spot checks with literal expectations.
module tb_store_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } entry_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Index 0 drives the 32-bit instance, index 1 the 64-bit instance.
    logic        in_valid  [2];
    logic [31:0] in_addr   [2];
    logic [1:0]  in_size   [2];
    logic [63:0] in_data   [2];
    logic        in_mready [2];
    logic [31:0] in_ld     [2];

    wire         out_ready  [2];
    wire         out_err    [2];
    wire         out_mvalid [2];
    wire         out_conf   [2];
    wire         out_empty  [2];
    wire [31:0]  out_maddr  [2];
    wire [63:0]  out_mdata  [2];
    wire [7:0]   out_strb   [2];
    wire [2:0]   out_count  [2];
    wire [31:0]  data32;
    wire [3:0]   strb32;

    assign out_mdata[0] = {32'd0, data32};
    assign out_strb[0]  = {4'd0, strb32};

    store_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) u_dut32 (
        .ACLK(clk), .ARESETn(rst_n),
        .req_valid(in_valid[0]), .req_ready(out_ready[0]), .req_addr(in_addr[0]),
        .req_size(in_size[0]), .req_data(in_data[0][31:0]), .misalign_err(out_err[0]),
        .mem_valid(out_mvalid[0]), .mem_ready(in_mready[0]), .mem_addr(out_maddr[0]),
        .mem_data(data32), .mem_strb(strb32), .ld_addr(in_ld[0]),
        .ld_conflict(out_conf[0]), .empty(out_empty[0]), .count(out_count[0])
    );

    store_queue #(.DATA_W(64), .ADDR_W(32), .DEPTH(DEPTH)) u_dut64 (
        .ACLK(clk), .ARESETn(rst_n),
        .req_valid(in_valid[1]), .req_ready(out_ready[1]), .req_addr(in_addr[1]),
        .req_size(in_size[1]), .req_data(in_data[1]), .misalign_err(out_err[1]),
        .mem_valid(out_mvalid[1]), .mem_ready(in_mready[1]), .mem_addr(out_maddr[1]),
        .mem_data(out_mdata[1]), .mem_strb(out_strb[1]), .ld_addr(in_ld[1]),
        .ld_conflict(out_conf[1]), .empty(out_empty[1]), .count(out_count[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    entry_t q32[$];
    entry_t q64[$];
    bit     exp_err [2];
    bit     known = 1'b0;

    function automatic int width_of(input int d);
        return (d == 0) ? 32 : 64;
    endfunction

    function automatic int m_size(input int d);
        return (d == 0) ? q32.size() : q64.size();
    endfunction

    function automatic entry_t m_head(input int d);
        return (d == 0) ? q32[0] : q64[0];
    endfunction

    function automatic void m_push(input int d, input entry_t e);
        if (d == 0) q32.push_back(e); else q64.push_back(e);
    endfunction

    function automatic void m_pop(input int d);
        if (d == 0) void'(q32.pop_front()); else void'(q64.pop_front());
    endfunction

    function automatic void m_clear(input int d);
        if (d == 0) q32.delete(); else q64.delete();
    endfunction

    function automatic bit m_conflict(input int d, input logic [31:0] ld);
        logic [31:0] w = ld - (ld % 32'(width_of(d) / 8));
        if (d == 0) begin
            foreach (q32[i]) if (q32[i].addr == w) return 1'b1;
        end else begin
            foreach (q64[i]) if (q64[i].addr == w) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Store encoding straight from the lane rules: nbytes at byte offset off within the word.
    function automatic void encode(input int w, input logic [31:0] a, input logic [1:0] s,
                                   input logic [63:0] pay, output bit legal, output entry_t e);
        int nb    = 1 << s;
        int bytes = w / 8;
        int off   = int'(a % 32'(bytes));
        logic [63:0] m;
        legal  = (nb <= bytes) && ((off % nb) == 0);
        m      = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        e.addr = a - 32'(off);
        e.strb = 8'(((1 << nb) - 1) << off);
        e.data = (pay & m) << (8 * off);
    endfunction

    // Compare every output against the model, then advance the model across the coming edge.
    task automatic tick();
        #1;
        for (int d = 0; d < 2; d++) begin
            if (known) begin
                string  p = (d == 0) ? "d32." : "d64.";
                int     n = m_size(d);
                entry_t h;
                check({p, "req_ready"}, 64'(out_ready[d]), 64'(n < DEPTH));
                check({p, "empty"}, 64'(out_empty[d]), 64'(n == 0));
                check({p, "count"}, 64'(out_count[d]), 64'(n));
                check({p, "mem_valid"}, 64'(out_mvalid[d]), 64'(n != 0));
                check({p, "misalign_err"}, 64'(out_err[d]), 64'(exp_err[d]));
                check({p, "ld_conflict"}, 64'(out_conf[d]), 64'(m_conflict(d, in_ld[d])));
                if (n != 0) begin
                    h = m_head(d);
                    check({p, "mem_addr"}, 64'(out_maddr[d]), 64'(h.addr));
                    check({p, "mem_data"}, out_mdata[d], h.data);
                    check({p, "mem_strb"}, 64'(out_strb[d]), 64'(h.strb));
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            int     n = m_size(d);
            bit     legal;
            bit     acc;
            entry_t e;
            if (!rst_n) begin
                m_clear(d);
                exp_err[d] = 1'b0;
            end else begin
                encode(width_of(d), in_addr[d], in_size[d], in_data[d], legal, e);
                acc = in_valid[d] && (n < DEPTH);
                if (in_mready[d] && n > 0) m_pop(d);
                if (acc && legal) m_push(d, e);
                exp_err[d] = acc && !legal;
            end
        end
        if (!rst_n) known = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_addr[d]   = '0;
            in_size[d]   = '0;
            in_data[d]   = '0;
            in_mready[d] = 1'b0;
            in_ld[d]     = '0;
        end
    endtask

    task automatic store(input int d, input logic [31:0] a, input logic [1:0] s, input logic [63:0] v);
        in_valid[d] = 1'b1;
        in_addr[d]  = a;
        in_size[d]  = s;
        in_data[d]  = v;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        tick();
        rst_n = 1'b1;

        // Reset state on both instances.
        for (int d = 0; d < 2; d++) begin
            check("rst.req_ready", 64'(out_ready[d]), 64'd1);
            check("rst.empty", 64'(out_empty[d]), 64'd1);
            check("rst.count", 64'(out_count[d]), 64'd0);
            check("rst.mem_valid", 64'(out_mvalid[d]), 64'd0);
            check("rst.misalign", 64'(out_err[d]), 64'd0);
            check("rst.mem_addr", 64'(out_maddr[d]), 64'd0);
            check("rst.mem_data", out_mdata[d], 64'd0);
            check("rst.mem_strb", 64'(out_strb[d]), 64'd0);
        end

        // Byte store at the top lane of a 32-bit word; upper payload bits are ignored.
        store(0, 32'h1003, 2'b00, 64'h1234_56AB);
        in_mready[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        check("sb.mem_valid", 64'(out_mvalid[0]), 64'd1);
        check("sb.mem_addr", 64'(out_maddr[0]), 64'h1000);
        check("sb.mem_strb", 64'(out_strb[0]), 64'h8);
        check("sb.mem_data", out_mdata[0], 64'hAB00_0000);
        tick();
        check("sb.empty_after", 64'(out_empty[0]), 64'd1);
        in_mready[0] = 1'b0;

        // Misaligned half-word, then a doubleword on the 32-bit port.
        store(0, 32'h2001, 2'b01, 64'h5555);
        tick();
        in_valid[0] = 1'b0;
        check("sh_mis.err", 64'(out_err[0]), 64'd1);
        check("sh_mis.count", 64'(out_count[0]), 64'd0);
        check("sh_mis.mem_valid", 64'(out_mvalid[0]), 64'd0);
        tick();
        check("sh_mis.err_drop", 64'(out_err[0]), 64'd0);
        store(0, 32'h2000, 2'b11, 64'h1);
        tick();
        in_valid[0] = 1'b0;
        check("sd32.err", 64'(out_err[0]), 64'd1);
        check("sd32.mem_valid", 64'(out_mvalid[0]), 64'd0);
        tick();
        check("sd32.err_drop", 64'(out_err[0]), 64'd0);

        // Back-to-back illegal accepts keep the error high.
        store(0, 32'h2003, 2'b01, 64'h1);
        tick();
        store(0, 32'h2002, 2'b10, 64'h1);
        tick();
        in_valid[0] = 1'b0;
        check("b2b.err_second", 64'(out_err[0]), 64'd1);
        tick();
        check("b2b.err_drop", 64'(out_err[0]), 64'd0);

        // 64-bit port: full doubleword, then an upper-half word.
        store(1, 32'h38, 2'b11, 64'h1122_3344_5566_7788);
        tick();
        check("sd64.mem_strb", 64'(out_strb[1]), 64'hFF);
        check("sd64.mem_data", out_mdata[1], 64'h1122_3344_5566_7788);
        store(1, 32'h3C, 2'b10, 64'hCAFE_0000_DEAD_BEEF);
        in_mready[1] = 1'b1;
        tick();
        in_valid[1]  = 1'b0;
        in_mready[1] = 1'b0;
        check("sw64.mem_addr", 64'(out_maddr[1]), 64'h38);
        check("sw64.mem_strb", 64'(out_strb[1]), 64'hF0);
        check("sw64.mem_data", out_mdata[1], 64'hDEAD_BEEF_0000_0000);
        in_mready[1] = 1'b1;
        tick();
        in_mready[1] = 1'b0;

        // Fill to DEPTH with back-pressure; the fifth store is refused.
        for (int i = 0; i < 5; i++) begin
            store(0, 32'h400 + 32'(4 * i), 2'b10, 64'hA0 + 64'(i));
            tick();
        end
        in_valid[0] = 1'b0;
        check("full.count", 64'(out_count[0]), 64'd4);
        check("full.req_ready", 64'(out_ready[0]), 64'd0);
        tick();
        check("stall.mem_data", out_mdata[0], 64'hA0);
        in_mready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain.order", out_mdata[0], 64'hA0 + 64'(i));
            tick();
        end
        check("drain.empty", 64'(out_empty[0]), 64'd1);
        in_mready[0] = 1'b0;
        store(0, 32'h500, 2'b10, 64'h77);
        tick();
        store(0, 32'h504, 2'b10, 64'h88);
        tick();
        in_valid[0] = 1'b0;
        check("wrap.head_addr", 64'(out_maddr[0]), 64'h500);
        check("wrap.count", 64'(out_count[0]), 64'd2);
        in_mready[0] = 1'b1;
        tick();
        tick();
        in_mready[0] = 1'b0;

        // Load conflict lookup on the word holding 0x100.
        store(0, 32'h100, 2'b10, 64'h1);
        tick();
        in_valid[0] = 1'b0;
        in_ld[0] = 32'h102;
        #1 check("ld.same_word", 64'(out_conf[0]), 64'd1);
        in_ld[0] = 32'h104;
        #1 check("ld.next_word", 64'(out_conf[0]), 64'd0);
        in_mready[0] = 1'b1;
        tick();
        in_mready[0] = 1'b0;
        in_ld[0] = 32'h102;
        #1 check("ld.drained_same", 64'(out_conf[0]), 64'd0);
        in_ld[0] = 32'h104;
        #1 check("ld.drained_next", 64'(out_conf[0]), 64'd0);

        // Reset with entries pending.
        for (int i = 0; i < 3; i++) begin
            store(0, 32'h600 + 32'(4 * i), 2'b10, 64'hF0 + 64'(i));
            tick();
        end
        in_valid[0] = 1'b0;
        check("prerst.count", 64'(out_count[0]), 64'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst.count", 64'(out_count[0]), 64'd0);
        check("midrst.mem_valid", 64'(out_mvalid[0]), 64'd0);
        check("midrst.mem_addr", 64'(out_maddr[0]), 64'd0);
        check("midrst.mem_data", out_mdata[0], 64'd0);
        check("midrst.mem_strb", 64'(out_strb[0]), 64'd0);
        check("midrst.req_ready", 64'(out_ready[0]), 64'd1);

        // Randomised traffic with varying back-pressure and rare resets.
        for (int c = 0; c < 3000; c++) begin
            int thr;
            case ((c / 200) % 3)
                0:       thr = 20;
                1:       thr = 50;
                default: thr = 90;
            endcase
            rst_n = ($urandom_range(0, 299) != 0);
            for (int d = 0; d < 2; d++) begin
                in_valid[d]  = ($urandom_range(0, 3) != 0);
                in_addr[d]   = 32'h100 + 32'($urandom_range(0, 47));
                in_size[d]   = 2'($urandom_range(0, 3));
                in_data[d]   = {$urandom, $urandom};
                in_mready[d] = ($urandom_range(0, 99) < thr);
                in_ld[d]     = 32'h100 + 32'($urandom_range(0, 47));
            end
            tick();
        end
        rst_n = 1'b1;
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
